// File: rtl/sync_fifo_lvl.sv
// rtl/sync_fifo_lvl.sv - single-clock FWFT FIFO with fill level, thresholds, flush and sticky errors
module sync_fifo_lvl #(
    parameter int DSIZE      = 8,
    parameter int ASIZE      = 4,
    parameter int AF_LEVEL   = (1 << ASIZE) - 1,
    parameter int AE_LEVEL   = 1,
    parameter bit OPT_WRFULL = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_clr_err,
    input  logic             i_wr,
    input  logic [DSIZE-1:0] i_wdata,
    output logic             o_wfull,
    output logic             o_walmost_full,
    input  logic             i_rd,
    output logic [DSIZE-1:0] o_rdata,
    output logic             o_rempty,
    output logic             o_ralmost_empty,
    output logic [ASIZE:0]   o_fill,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam int             DEPTH   = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_L = (ASIZE+1)'(1) << ASIZE;
    localparam logic [ASIZE:0] AF_L    = (ASIZE+1)'(AF_LEVEL);
    localparam logic [ASIZE:0] AE_L    = (ASIZE+1)'(AE_LEVEL);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE-1:0] wptr, rptr;
    logic [ASIZE:0]   fill_nxt;
    logic             rd_ok, wr_ok, wr_en, rd_en;
    logic             ovf_evt, unf_evt;

    assign rd_ok = i_rd & ~o_rempty;
    assign wr_ok = i_wr & (~o_wfull | (OPT_WRFULL & rd_ok));

    // Flush suppresses every side effect of a same-cycle read or write.
    assign wr_en   = wr_ok & ~i_flush;
    assign rd_en   = rd_ok & ~i_flush;
    assign ovf_evt = i_wr & ~wr_ok & ~i_flush;
    assign unf_evt = i_rd & o_rempty & ~i_flush;

    assign o_rdata = mem[rptr];

    always_comb begin
        fill_nxt = o_fill;
        if (i_flush)
            fill_nxt = '0;
        else if (wr_en && !rd_en)
            fill_nxt = o_fill + 1'b1;
        else if (!wr_en && rd_en)
            fill_nxt = o_fill - 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem[wptr] <= i_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr            <= '0;
            rptr            <= '0;
            o_fill          <= '0;
            o_wfull         <= 1'b0;
            o_walmost_full  <= 1'b0;
            o_rempty        <= 1'b1;
            o_ralmost_empty <= 1'b1;
            o_overflow      <= 1'b0;
            o_underflow     <= 1'b0;
        end else begin
            if (i_flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_en)
                    wptr <= wptr + 1'b1;
                if (rd_en)
                    rptr <= rptr + 1'b1;
            end
            // Status flags are registered from the post-edge fill so they carry no lag.
            o_fill          <= fill_nxt;
            o_wfull         <= (fill_nxt == DEPTH_L);
            o_walmost_full  <= (fill_nxt >= AF_L);
            o_rempty        <= (fill_nxt == '0);
            o_ralmost_empty <= (fill_nxt <= AE_L);
            if (ovf_evt)
                o_overflow <= 1'b1;
            else if (i_clr_err)
                o_overflow <= 1'b0;
            if (unf_evt)
                o_underflow <= 1'b1;
            else if (i_clr_err)
                o_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// tb/tb_sync_fifo_lvl.sv - directed vector bench for sync_fifo_lvl
module tb_sync_fifo_lvl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       fl0, clr0, wr0, rd0;
    logic [7:0] wd0, rdata0;
    logic       full0, af0, emp0, ae0, ovf0, unf0;
    logic [2:0] fill0;

    logic       fl1, clr1, wr1, rd1;
    logic [7:0] wd1, rdata1;
    logic       full1, af1, emp1, ae1, ovf1, unf1;
    logic [2:0] fill1;

    sync_fifo_lvl #(.DSIZE(8), .ASIZE(2), .AF_LEVEL(3), .AE_LEVEL(1), .OPT_WRFULL(1'b0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(fl0), .i_clr_err(clr0),
        .i_wr(wr0), .i_wdata(wd0), .o_wfull(full0), .o_walmost_full(af0),
        .i_rd(rd0), .o_rdata(rdata0), .o_rempty(emp0), .o_ralmost_empty(ae0),
        .o_fill(fill0), .o_overflow(ovf0), .o_underflow(unf0)
    );

    sync_fifo_lvl #(.DSIZE(8), .ASIZE(2), .AF_LEVEL(3), .AE_LEVEL(1), .OPT_WRFULL(1'b1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(fl1), .i_clr_err(clr1),
        .i_wr(wr1), .i_wdata(wd1), .o_wfull(full1), .o_walmost_full(af1),
        .i_rd(rd1), .o_rdata(rdata1), .o_rempty(emp1), .o_ralmost_empty(ae1),
        .o_fill(fill1), .o_overflow(ovf1), .o_underflow(unf1)
    );

    typedef struct {
        logic       wr, rd, fl, clr;
        logic [7:0] wd;
        logic [2:0] fill;
        logic       emp, ful, af, ae, ovf, unf;
        logic [7:0] rdat;
    } vec_t;

    vec_t tv[$];
    int   nvec  = 0;
    int   nfail = 0;

    function automatic vec_t mk(logic wr, logic rd, logic fl, logic clr, logic [7:0] wd,
                                logic [2:0] fill, logic emp, logic ful, logic af, logic ae,
                                logic ovf, logic unf, logic [7:0] rdat);
        vec_t v;
        v.wr = wr; v.rd = rd; v.fl = fl; v.clr = clr; v.wd = wd;
        v.fill = fill; v.emp = emp; v.ful = ful; v.af = af; v.ae = ae;
        v.ovf = ovf; v.unf = unf; v.rdat = rdat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_dut0(input string tag, input vec_t v);
        check({tag, ".fill"}, 32'(fill0), 32'(v.fill));
        check({tag, ".empty"}, 32'(emp0), 32'(v.emp));
        check({tag, ".full"}, 32'(full0), 32'(v.ful));
        check({tag, ".afull"}, 32'(af0), 32'(v.af));
        check({tag, ".aempty"}, 32'(ae0), 32'(v.ae));
        check({tag, ".ovf"}, 32'(ovf0), 32'(v.ovf));
        check({tag, ".unf"}, 32'(unf0), 32'(v.unf));
        if (!v.emp)
            check({tag, ".rdata"}, 32'(rdata0), 32'(v.rdat));
    endtask

    task automatic step1(input logic wr, input logic rd, input logic [7:0] wd);
        @(negedge clk);
        wr1 = wr; rd1 = rd; wd1 = wd;
        @(posedge clk);
        #1;
        wr1 = 1'b0; rd1 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        {fl0, clr0, wr0, rd0, wd0} = '0;
        {fl1, clr1, wr1, rd1, wd1} = '0;

        //        wr rd fl clr wd     fill emp ful af ae ovf unf rdata
        tv.push_back(mk(1, 0, 0, 0, 8'h11, 1, 0, 0, 0, 1, 0, 0, 8'h11));
        tv.push_back(mk(1, 0, 0, 0, 8'h22, 2, 0, 0, 0, 0, 0, 0, 8'h11));
        tv.push_back(mk(1, 0, 0, 0, 8'h33, 3, 0, 0, 1, 0, 0, 0, 8'h11));
        tv.push_back(mk(1, 0, 0, 0, 8'h44, 4, 0, 1, 1, 0, 0, 0, 8'h11));
        tv.push_back(mk(0, 1, 0, 0, 8'h00, 3, 0, 0, 1, 0, 0, 0, 8'h22));
        tv.push_back(mk(0, 1, 0, 0, 8'h00, 2, 0, 0, 0, 0, 0, 0, 8'h33));
        tv.push_back(mk(0, 1, 0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 8'h44));
        tv.push_back(mk(0, 1, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'h00));
        tv.push_back(mk(1, 0, 0, 0, 8'h11, 1, 0, 0, 0, 1, 0, 0, 8'h11));
        tv.push_back(mk(1, 0, 0, 0, 8'h22, 2, 0, 0, 0, 0, 0, 0, 8'h11));
        tv.push_back(mk(1, 0, 0, 0, 8'h33, 3, 0, 0, 1, 0, 0, 0, 8'h11));
        tv.push_back(mk(1, 0, 0, 0, 8'h44, 4, 0, 1, 1, 0, 0, 0, 8'h11));
        tv.push_back(mk(1, 1, 0, 0, 8'h55, 3, 0, 0, 1, 0, 1, 0, 8'h22));
        tv.push_back(mk(0, 0, 0, 1, 8'h00, 3, 0, 0, 1, 0, 0, 0, 8'h22));
        tv.push_back(mk(0, 1, 0, 0, 8'h00, 2, 0, 0, 0, 0, 0, 0, 8'h33));
        tv.push_back(mk(0, 1, 0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 8'h44));
        tv.push_back(mk(0, 1, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'h00));
        tv.push_back(mk(1, 1, 0, 0, 8'h66, 1, 0, 0, 0, 1, 0, 1, 8'h66));
        tv.push_back(mk(0, 0, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 8'h66));
        tv.push_back(mk(0, 1, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'h00));
        tv.push_back(mk(0, 1, 0, 1, 8'h00, 0, 1, 0, 0, 1, 0, 1, 8'h00));
        tv.push_back(mk(0, 0, 0, 1, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'h00));
        tv.push_back(mk(1, 0, 0, 0, 8'hA0, 1, 0, 0, 0, 1, 0, 0, 8'hA0));
        tv.push_back(mk(1, 0, 0, 0, 8'hA1, 2, 0, 0, 0, 0, 0, 0, 8'hA0));
        tv.push_back(mk(1, 0, 0, 0, 8'hA2, 3, 0, 0, 1, 0, 0, 0, 8'hA0));
        tv.push_back(mk(1, 1, 1, 0, 8'h99, 0, 1, 0, 0, 1, 0, 0, 8'h00));
        tv.push_back(mk(1, 0, 0, 0, 8'h77, 1, 0, 0, 0, 1, 0, 0, 8'h77));
        tv.push_back(mk(0, 1, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'h00));

        repeat (2) @(posedge clk);
        #1;
        check_dut0("reset", mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'h00));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            @(negedge clk);
            wr0 = tv[i].wr; rd0 = tv[i].rd; fl0 = tv[i].fl; clr0 = tv[i].clr; wd0 = tv[i].wd;
            @(posedge clk);
            #1;
            check_dut0($sformatf("vec%0d", i), tv[i]);
        end
        @(negedge clk);
        {fl0, clr0, wr0, rd0} = '0;

        // Steady fill of 2 while streaming through the pointer wrap several times.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            wr0 = 1'b1; wd0 = 8'h80 + 8'(i);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("wrap%0d.rdata", i), 32'(rdata0), 32'(8'h80 + 8'(i)));
            wr0 = 1'b1; rd0 = 1'b1; wd0 = 8'h82 + 8'(i);
        end
        @(negedge clk);
        wr0 = 1'b0; rd0 = 1'b0;
        check("wrap.fill", 32'(fill0), 32'd2);
        check("wrap.errs", 32'({ovf0, unf0}), 32'd0);
        check("wrap.head", 32'(rdata0), 32'h8A);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_dut0("async_rst", mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'h00));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wr0 = 1'b1; wd0 = 8'h5A;
        @(negedge clk);
        wr0 = 1'b0;
        check("post_rst.fill", 32'(fill0), 32'd1);
        check("post_rst.rdata", 32'(rdata0), 32'h5A);
        rd0 = 1'b1;
        @(negedge clk);
        rd0 = 1'b0;
        check("post_rst.empty", 32'(emp0), 32'd1);

        // Write-while-full acceptance variant.
        step1(1, 0, 8'h11);
        step1(1, 0, 8'h22);
        step1(1, 0, 8'h33);
        step1(1, 0, 8'h44);
        check("wf.full", 32'(full1), 32'd1);
        step1(1, 1, 8'h55);
        check("wf.fill", 32'(fill1), 32'd4);
        check("wf.full2", 32'(full1), 32'd1);
        check("wf.ovf", 32'(ovf1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wf.rd%0d", i), 32'(rdata1), 32'(8'h22 + 8'h11 * 8'(i)));
            step1(0, 1, 8'h00);
        end
        check("wf.empty", 32'(emp1), 32'd1);
        check("wf.unf", 32'(unf1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
